// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a DIGITS-wide 7-segment display with a
// frame-aligned value update, leading-zero blanking, decimal points and output polarity.
module seg7_scan_driver #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  lzb,
   input  logic                  blank,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   active;
   logic [4*DIGITS-1:0]   pending;
   logic [DIGITS-1:0]     adp;
   logic [DIGITS-1:0]     pdp;
   logic                  pend;

   logic                  tick;
   logic                  last;
   logic                  boundary;
   logic [3:0]            nib;
   logic [DIGITS-1:0]     lz_blank;
   logic                  zero_above;
   logic [6:0]            seg_n;
   logic                  dp_n;
   logic [DIGITS-1:0]     an_n;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h7E;
         4'h1: s = 7'h30;
         4'h2: s = 7'h6D;
         4'h3: s = 7'h79;
         4'h4: s = 7'h33;
         4'h5: s = 7'h5B;
         4'h6: s = 7'h5F;
         4'h7: s = 7'h70;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h7B;
         4'hA: s = 7'h77;
         4'hB: s = 7'h1F;
         4'hC: s = 7'h4E;
         4'hD: s = 7'h3D;
         4'hE: s = 7'h4F;
         default: s = 7'h47;
      endcase
      return s;
   endfunction

   assign tick     = (cnt == CW'(REFRESH_DIV - 1));
   assign last     = (idx == IW'(DIGITS - 1));
   assign boundary = tick && last;
   assign nib      = active[idx*4 +: 4];

   // A digit is a leading zero when it and every more-significant nibble are zero.
   always_comb begin
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
         zero_above  = zero_above && (active[k*4 +: 4] == 4'h0);
         lz_blank[k] = zero_above;
      end
   end

   always_comb begin
      an_n      = '0;
      an_n[idx] = 1'b1;
      if (blank || (lzb && lz_blank[idx]))
         seg_n = '0;
      else
         seg_n = hex_to_seg(nib);
      dp_n = !blank && adp[idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         idx     <= '0;
         active  <= '0;
         pending <= '0;
         adp     <= '0;
         pdp     <= '0;
         pend    <= 1'b0;
         frame   <= 1'b0;
         seg     <= {7{ACTIVE_LOW}};
         dp      <= ACTIVE_LOW;
         an      <= {DIGITS{ACTIVE_LOW}};
      end else begin
         cnt   <= tick ? '0 : cnt + CW'(1);
         frame <= boundary;
         if (tick)
            idx <= last ? '0 : idx + IW'(1);

         // A load landing on the boundary goes straight to active so it is never split or lost.
         if (boundary) begin
            pend <= 1'b0;
            if (load) begin
               active <= din;
               adp    <= dp_in;
            end else if (pend) begin
               active <= pending;
               adp    <= pdp;
            end
         end else if (load) begin
            pending <= din;
            pdp     <= dp_in;
            pend    <= 1'b1;
         end

         seg <= seg_n ^ {7{ACTIVE_LOW}};
         dp  <= dp_n ^ ACTIVE_LOW;
         an  <= an_n ^ {DIGITS{ACTIVE_LOW}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, REFRESH_DIV=4, one instance per polarity.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic        lzb;
   logic        blank;

   logic [6:0]  seg_h, seg_l;
   logic        dp_h, dp_l;
   logic [3:0]  an_h, an_l;
   logic        frame_h, frame_l;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_h (
      .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dp_in),
      .lzb(lzb), .blank(blank), .seg(seg_h), .dp(dp_h), .an(an_h), .frame(frame_h)
   );

   seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_l (
      .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dp_in),
      .lzb(lzb), .blank(blank), .seg(seg_l), .dp(dp_l), .an(an_l), .frame(frame_l)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
      din   = v;
      dp_in = dpv;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_frame();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (frame_h !== 1'b1 && k < 40);
      if (frame_h !== 1'b1) begin
         vectors++;
         miscompares++;
         $error("FAIL frame_timeout: got frame=%0b expected 1 within 40 cycles", frame_h);
      end
   endtask

   // Called on the sample where frame is high; checks one whole frame and ends on the next frame sample.
   task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpe);
      logic [6:0] es [4];
      es = '{s0, s1, s2, s3};
      for (int d = 0; d < 4; d++) begin
         step(2);
         chk({tag, "_an"}, an_h, 32'd1 << d);
         chk({tag, "_seg"}, seg_h, es[d]);
         chk({tag, "_dp"}, dp_h, dpe[d]);
         step(2);
      end
      chk({tag, "_frame"}, frame_h, 1);
   endtask

   initial begin
      reset = 1'b1;
      load  = 1'b0;
      din   = '0;
      dp_in = '0;
      lzb   = 1'b0;
      blank = 1'b0;
      step(2);
      chk("rst_seg_h", seg_h, 7'h00);
      chk("rst_an_h", an_h, 4'h0);
      chk("rst_dp_h", dp_h, 1'b0);
      chk("rst_frame", frame_h, 1'b0);
      chk("rst_seg_l", seg_l, 7'h7F);
      chk("rst_an_l", an_l, 4'hF);
      chk("rst_dp_l", dp_l, 1'b1);
      reset = 1'b0;

      // scan timing: each digit held 4 cycles, frame on every 16th sample
      for (int n = 1; n <= 32; n++) begin
         step(1);
         chk("scan_an", an_h, 32'd1 << (((n - 1) / 4) % 4));
         chk("scan_frame", frame_h, (n % 16 == 0) ? 1 : 0);
         if (n == 1) chk("first_seg", seg_h, 7'h7E);
      end

      // decode sweep over all 16 codes
      do_load(16'h0123, 4'h0); wait_frame(); check_frame("dec0123", 7'h79, 7'h6D, 7'h30, 7'h7E, 4'h0);
      do_load(16'h4567, 4'h0); wait_frame(); check_frame("dec4567", 7'h70, 7'h5F, 7'h5B, 7'h33, 4'h0);
      do_load(16'h89AB, 4'h0); wait_frame(); check_frame("dec89AB", 7'h1F, 7'h77, 7'h7B, 7'h7F, 4'h0);
      do_load(16'hCDEF, 4'h0); wait_frame(); check_frame("decCDEF", 7'h47, 7'h4F, 7'h3D, 7'h4E, 4'h0);

      // back-to-back loads: last wins
      do_load(16'h3333, 4'h0);
      do_load(16'h1111, 4'h0);
      wait_frame();
      check_frame("b2b", 7'h30, 7'h30, 7'h30, 7'h30, 4'h0);

      // tear-free: load while digit 1 is scanned, digits 2/3 keep the old value
      step(5);
      do_load(16'h2222, 4'h0);
      step(4);
      chk("tear_an2", an_h, 4'b0100);
      chk("tear_seg2", seg_h, 7'h30);
      step(4);
      chk("tear_an3", an_h, 4'b1000);
      chk("tear_seg3", seg_h, 7'h30);
      step(2);
      chk("tear_frame", frame_h, 1'b1);
      check_frame("tear_new", 7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'h0);

      // leading-zero blanking
      lzb = 1'b1;
      do_load(16'h0050, 4'h0); wait_frame(); check_frame("lzb0050", 7'h7E, 7'h5B, 7'h00, 7'h00, 4'h0);
      do_load(16'h0000, 4'h0); wait_frame(); check_frame("lzb0000", 7'h7E, 7'h00, 7'h00, 7'h00, 4'h0);

      // decimal point (also on a blanked digit), then global blank
      do_load(16'h0000, 4'b0100); wait_frame(); check_frame("dp", 7'h7E, 7'h00, 7'h00, 7'h00, 4'b0100);
      blank = 1'b1;
      check_frame("blank", 7'h00, 7'h00, 7'h00, 7'h00, 4'h0);
      blank = 1'b0;

      // reset mid-frame while digit 2 is being scanned
      step(9);
      reset = 1'b1;
      step(1);
      chk("midrst_seg_l", seg_l, 7'h7F);
      chk("midrst_an_l", an_l, 4'hF);
      chk("midrst_dp_l", dp_l, 1'b1);
      chk("midrst_frame", frame_h, 1'b0);
      reset = 1'b0;
      step(1);
      chk("restart_seg_l", seg_l, 7'h01);
      chk("restart_an_l", an_l, 4'b1110);
      chk("restart_dp_l", dp_l, 1'b1);
      chk("restart_an_h", an_h, 4'b0001);
      step(3);
      chk("restart_hold", an_h, 4'b0001);
      step(1);
      chk("restart_next", an_h, 4'b0010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
